// File: rtl/match_controller_pkg.sv
// Shared encodings for the round/match sequencer: FSM states, winner codes, and the blank 7-segment pattern.
package match_controller_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTRO      = 3'd1,
    FIGHT      = 3'd2,
    ROUND_END  = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/match_controller_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern (gfedcba); non-decimal codes blank.
module seg7_decoder
  import match_controller_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: intro freeze, timed fight with KO/timeout resolution, post-round hold,
// best-of-N match tracking, and 7-segment display of timer and round wins.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC   = 60,
  parameter int unsigned ROUND_SECONDS    = 99,
  parameter int unsigned INTRO_FRAMES     = 120,
  parameter int unsigned ROUND_END_FRAMES = 180,
  parameter int unsigned ROUNDS_TO_WIN    = 2,
  parameter int unsigned MAX_ROUNDS       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] p1_health,
  input  logic [2:0] p2_health,
  output logic       game_active,
  output logic       round_reset,
  output logic [2:0] match_state,
  output logic [6:0] timer_sec,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner,
  output logic [6:0] hex_timer_lo,
  output logic [6:0] hex_timer_hi,
  output logic [6:0] hex_p1,
  output logic [6:0] hex_p2
);

  localparam int unsigned CNT_MAX_A = (FRAMES_PER_SEC > INTRO_FRAMES) ? FRAMES_PER_SEC : INTRO_FRAMES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > ROUND_END_FRAMES) ? CNT_MAX_A : ROUND_END_FRAMES;
  localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_t           state;
  logic             start_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [2:0]       round_cnt;
  logic             start_evt;
  logic             sec_wrap;
  logic             timeout;
  winner_t          result;

  assign start_evt   = start & ~start_q;
  assign sec_wrap    = (frame_cnt == CNT_W'(FRAMES_PER_SEC - 1));
  assign timeout     = (timer_sec == 7'd1) && sec_wrap;
  assign match_state = state;

  // KO outranks timeout; a double KO is a draw.
  always_comb begin
    result = WIN_NONE;
    if (p1_health == '0 && p2_health == '0)
      result = WIN_DRAW;
    else if (p2_health == '0)
      result = WIN_P1;
    else if (p1_health == '0)
      result = WIN_P2;
    else if (timeout) begin
      if (p1_health > p2_health)
        result = WIN_P1;
      else if (p2_health > p1_health)
        result = WIN_P2;
      else
        result = WIN_DRAW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b1;
      frame_cnt    <= '0;
      round_cnt    <= '0;
      timer_sec    <= 7'(ROUND_SECONDS);
      p1_rounds    <= '0;
      p2_rounds    <= '0;
      round_winner <= WIN_NONE;
      match_winner <= WIN_NONE;
      game_active  <= 1'b0;
      round_reset  <= 1'b0;
    end else begin
      start_q     <= start;
      round_reset <= 1'b0;
      case (state)
        IDLE, MATCH_OVER: begin
          if (start_evt) begin
            p1_rounds    <= '0;
            p2_rounds    <= '0;
            round_winner <= WIN_NONE;
            match_winner <= WIN_NONE;
            round_cnt    <= '0;
            frame_cnt    <= '0;
            round_reset  <= 1'b1;
            state        <= INTRO;
          end
        end
        INTRO: begin
          if (frame_cnt == CNT_W'(INTRO_FRAMES - 1)) begin
            frame_cnt   <= '0;
            timer_sec   <= 7'(ROUND_SECONDS);
            game_active <= 1'b1;
            state       <= FIGHT;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        FIGHT: begin
          if (sec_wrap && timer_sec != '0)
            timer_sec <= timer_sec - 7'd1;
          if (result != WIN_NONE) begin
            frame_cnt    <= '0;
            game_active  <= 1'b0;
            round_winner <= result;
            state        <= ROUND_END;
            if (round_cnt < 3'(MAX_ROUNDS))
              round_cnt <= round_cnt + 3'd1;
            if (result == WIN_P1 && p1_rounds < 2'(ROUNDS_TO_WIN))
              p1_rounds <= p1_rounds + 2'd1;
            if (result == WIN_P2 && p2_rounds < 2'(ROUNDS_TO_WIN))
              p2_rounds <= p2_rounds + 2'd1;
          end else begin
            frame_cnt <= sec_wrap ? '0 : frame_cnt + 1'b1;
          end
        end
        ROUND_END: begin
          if (frame_cnt == CNT_W'(ROUND_END_FRAMES - 1)) begin
            frame_cnt <= '0;
            if (p1_rounds == 2'(ROUNDS_TO_WIN) || p2_rounds == 2'(ROUNDS_TO_WIN) ||
                round_cnt == 3'(MAX_ROUNDS)) begin
              state <= MATCH_OVER;
              if (p1_rounds > p2_rounds)
                match_winner <= WIN_P1;
              else if (p2_rounds > p1_rounds)
                match_winner <= WIN_P2;
              else
                match_winner <= WIN_DRAW;
            end else begin
              round_reset <= 1'b1;
              state       <= INTRO;
            end
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [3:0] timer_lo_digit;
  logic [3:0] timer_hi_digit;

  assign timer_lo_digit = 4'(timer_sec % 7'd10);
  assign timer_hi_digit = 4'(timer_sec / 7'd10);

  seg7_decoder u_seg_timer_lo (.digit(timer_lo_digit),    .seg(hex_timer_lo));
  seg7_decoder u_seg_timer_hi (.digit(timer_hi_digit),    .seg(hex_timer_hi));
  seg7_decoder u_seg_p1       (.digit({2'b00, p1_rounds}), .seg(hex_p1));
  seg7_decoder u_seg_p2       (.digit({2'b00, p2_rounds}), .seg(hex_p2));

endmodule

// File: tb/tb_match_controller.sv
// Directed scenario bench for match_controller with a shortened frame/round configuration.
module tb_match_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] p1_health;
  logic [2:0] p2_health;
  logic       game_active;
  logic       round_reset;
  logic [2:0] match_state;
  logic [6:0] timer_sec;
  logic [1:0] p1_rounds;
  logic [1:0] p2_rounds;
  logic [1:0] round_winner;
  logic [1:0] match_winner;
  logic [6:0] hex_timer_lo;
  logic [6:0] hex_timer_hi;
  logic [6:0] hex_p1;
  logic [6:0] hex_p2;

  int unsigned total;
  int unsigned bad;

  match_controller #(
    .FRAMES_PER_SEC(4),
    .ROUND_SECONDS(3),
    .INTRO_FRAMES(2),
    .ROUND_END_FRAMES(3),
    .ROUNDS_TO_WIN(2),
    .MAX_ROUNDS(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_health(p1_health), .p2_health(p2_health),
    .game_active(game_active), .round_reset(round_reset), .match_state(match_state),
    .timer_sec(timer_sec), .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
    .round_winner(round_winner), .match_winner(match_winner),
    .hex_timer_lo(hex_timer_lo), .hex_timer_hi(hex_timer_hi),
    .hex_p1(hex_p1), .hex_p2(hex_p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; p1_health = 3'd7; p2_health = 3'd7;
    tick(2);
    rst = 1'b0;
    tick(3);
    total++; if (match_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", match_state); end
    total++; if (timer_sec !== 7'd3) begin bad++; $display("FAIL reset_timer got=%0d want=3", timer_sec); end
    total++; if ({p1_rounds, p2_rounds, round_winner, match_winner} !== 8'h00) begin bad++;
      $display("FAIL reset_scores got=%h want=00", {p1_rounds, p2_rounds, round_winner, match_winner}); end
    total++; if ({game_active, round_reset} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {game_active, round_reset}); end
    total++; if (hex_timer_hi !== 7'b1000000) begin bad++; $display("FAIL reset_hex_hi got=%b want=1000000", hex_timer_hi); end
  endtask

  task automatic test_start;
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    total++; if (match_state !== 3'd1) begin bad++; $display("FAIL start_intro got=%0d want=1", match_state); end
    total++; if (round_reset !== 1'b1) begin bad++; $display("FAIL start_rr_hi got=%b want=1", round_reset); end
    start = 1'b0;
    tick(1);
    total++; if ({match_state, round_reset} !== {3'd1, 1'b0}) begin bad++;
      $display("FAIL start_rr_lo got=%0d/%b want=1/0", match_state, round_reset); end
    tick(1);
    total++; if (match_state !== 3'd2) begin bad++; $display("FAIL start_fight got=%0d want=2", match_state); end
    total++; if (timer_sec !== 7'd3) begin bad++; $display("FAIL start_timer got=%0d want=3", timer_sec); end
    total++; if (game_active !== 1'b1) begin bad++; $display("FAIL start_active got=%b want=1", game_active); end
    total++; if (hex_timer_lo !== 7'b0110000) begin bad++; $display("FAIL start_hex_lo got=%b want=0110000", hex_timer_lo); end
  endtask

  task automatic test_ko;
    tick(4);
    p2_health = 3'd0;
    tick(1);
    total++; if (match_state !== 3'd3) begin bad++; $display("FAIL ko_state got=%0d want=3", match_state); end
    total++; if (p1_rounds !== 2'd1) begin bad++; $display("FAIL ko_p1_rounds got=%0d want=1", p1_rounds); end
    total++; if (round_winner !== 2'b01) begin bad++; $display("FAIL ko_winner got=%b want=01", round_winner); end
    total++; if (game_active !== 1'b0) begin bad++; $display("FAIL ko_active got=%b want=0", game_active); end
    total++; if (timer_sec !== 7'd2) begin bad++; $display("FAIL ko_timer got=%0d want=2", timer_sec); end
    p2_health = 3'd7;
    tick(2);
    total++; if ({match_state, round_reset} !== {3'd3, 1'b0}) begin bad++;
      $display("FAIL ko_hold got=%0d/%b want=3/0", match_state, round_reset); end
    tick(1);
    total++; if ({match_state, round_reset} !== {3'd1, 1'b1}) begin bad++;
      $display("FAIL ko_next_round got=%0d/%b want=1/1", match_state, round_reset); end
  endtask

  task automatic test_timeout_win;
    tick(2);
    p1_health = 3'd5; p2_health = 3'd3;
    total++; if (timer_sec !== 7'd3) begin bad++; $display("FAIL to_timer3 got=%0d want=3", timer_sec); end
    tick(4);
    total++; if (timer_sec !== 7'd2) begin bad++; $display("FAIL to_timer2 got=%0d want=2", timer_sec); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    total++; if ({match_state, round_reset} !== {3'd2, 1'b0}) begin bad++;
      $display("FAIL to_start_ignored got=%0d/%b want=2/0", match_state, round_reset); end
    tick(3);
    total++; if (timer_sec !== 7'd1) begin bad++; $display("FAIL to_timer1 got=%0d want=1", timer_sec); end
    tick(3);
    total++; if ({match_state, timer_sec} !== {3'd2, 7'd1}) begin bad++;
      $display("FAIL to_frame12 got=%0d/%0d want=2/1", match_state, timer_sec); end
    tick(1);
    total++; if ({match_state, timer_sec} !== {3'd3, 7'd0}) begin bad++;
      $display("FAIL to_expired got=%0d/%0d want=3/0", match_state, timer_sec); end
    total++; if ({round_winner, p1_rounds} !== {2'b01, 2'd2}) begin bad++;
      $display("FAIL to_p1_win got=%b/%0d want=01/2", round_winner, p1_rounds); end
    p1_health = 3'd7; p2_health = 3'd7;
    tick(2);
    total++; if (timer_sec !== 7'd0) begin bad++; $display("FAIL to_frozen got=%0d want=0", timer_sec); end
    tick(1);
    total++; if ({match_state, match_winner} !== {3'd4, 2'b01}) begin bad++;
      $display("FAIL to_match_over got=%0d/%b want=4/01", match_state, match_winner); end
    total++; if (hex_p1 !== 7'b0100100) begin bad++; $display("FAIL to_hex_p1 got=%b want=0100100", hex_p1); end
  endtask

  task automatic test_timeout_draw;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    total++; if ({match_state, round_reset, p1_rounds, p2_rounds, round_winner, match_winner} !== {3'd1, 1'b1, 8'h00}) begin bad++;
      $display("FAIL restart got=%0d/%b/%0d/%0d/%b/%b want=1/1/0/0/00/00",
               match_state, round_reset, p1_rounds, p2_rounds, round_winner, match_winner); end
    tick(2);
    p1_health = 3'd4; p2_health = 3'd4;
    tick(12);
    total++; if ({match_state, round_winner, timer_sec} !== {3'd3, 2'b11, 7'd0}) begin bad++;
      $display("FAIL eq_draw got=%0d/%b/%0d want=3/11/0", match_state, round_winner, timer_sec); end
    total++; if ({p1_rounds, p2_rounds} !== 4'h0) begin bad++;
      $display("FAIL eq_no_inc got=%0d/%0d want=0/0", p1_rounds, p2_rounds); end
    p1_health = 3'd7; p2_health = 3'd7;
    tick(3);
    total++; if (match_state !== 3'd1) begin bad++; $display("FAIL eq_next got=%0d want=1", match_state); end
  endtask

  task automatic test_double_ko_timeout;
    tick(2);
    p1_health = 3'd6; p2_health = 3'd6;
    tick(11);
    p1_health = 3'd0; p2_health = 3'd0;
    tick(1);
    total++; if ({match_state, round_winner, timer_sec} !== {3'd3, 2'b11, 7'd0}) begin bad++;
      $display("FAIL dko_draw got=%0d/%b/%0d want=3/11/0", match_state, round_winner, timer_sec); end
    total++; if ({p1_rounds, p2_rounds} !== 4'h0) begin bad++;
      $display("FAIL dko_no_inc got=%0d/%0d want=0/0", p1_rounds, p2_rounds); end
    p1_health = 3'd7; p2_health = 3'd7;
    tick(3);
    total++; if (match_state !== 3'd1) begin bad++; $display("FAIL dko_next got=%0d want=1", match_state); end
  endtask

  task automatic test_p2_match;
    for (int r = 1; r <= 2; r++) begin
      tick(2);
      p1_health = 3'd0;
      tick(1);
      total++; if ({match_state, p2_rounds, round_winner} !== {3'd3, 2'(r), 2'b10}) begin bad++;
        $display("FAIL p2_round%0d got=%0d/%0d/%b want=3/%0d/10", r, match_state, p2_rounds, round_winner, r); end
      p1_health = 3'd7;
      tick(3);
    end
    total++; if ({match_state, match_winner} !== {3'd4, 2'b10}) begin bad++;
      $display("FAIL p2_match got=%0d/%b want=4/10", match_state, match_winner); end
    total++; if ({hex_p2, hex_p1} !== {7'b0100100, 7'b1000000}) begin bad++;
      $display("FAIL p2_hex got=%b/%b want=0100100/1000000", hex_p2, hex_p1); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    total++; if ({match_state, p2_rounds, match_winner, round_reset} !== {3'd1, 2'd0, 2'b00, 1'b1}) begin bad++;
      $display("FAIL p2_restart got=%0d/%0d/%b/%b want=1/0/00/1", match_state, p2_rounds, match_winner, round_reset); end
  endtask

  task automatic test_five_draws;
    for (int r = 1; r <= 5; r++) begin
      tick(2);
      p1_health = 3'd0; p2_health = 3'd0;
      tick(1);
      total++; if ({match_state, round_winner} !== {3'd3, 2'b11}) begin bad++;
        $display("FAIL draw%0d got=%0d/%b want=3/11", r, match_state, round_winner); end
      p1_health = 3'd7; p2_health = 3'd7;
      tick(3);
      if (r < 5) begin
        total++; if (match_state !== 3'd1) begin bad++; $display("FAIL draw%0d_next got=%0d want=1", r, match_state); end
      end else begin
        total++; if ({match_state, match_winner} !== {3'd4, 2'b11}) begin bad++;
          $display("FAIL draws_over got=%0d/%b want=4/11", match_state, match_winner); end
      end
    end
  endtask

  task automatic test_rst_mid_fight;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    tick(5);
    total++; if ({match_state, timer_sec} !== {3'd2, 7'd2}) begin bad++;
      $display("FAIL rst_pre got=%0d/%0d want=2/2", match_state, timer_sec); end
    rst = 1'b1;
    #1;
    total++; if ({match_state, timer_sec, game_active} !== {3'd0, 7'd3, 1'b0}) begin bad++;
      $display("FAIL rst_async got=%0d/%0d/%b want=0/3/0", match_state, timer_sec, game_active); end
    tick(1);
    rst = 1'b0;
    tick(2);
    total++; if ({match_state, round_reset} !== {3'd0, 1'b0}) begin bad++;
      $display("FAIL rst_idle got=%0d/%b want=0/0", match_state, round_reset); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_start();
    test_ko();
    test_timeout_win();
    test_timeout_draw();
    test_double_ko_timeout();
    test_p2_match();
    test_five_draws();
    test_rst_mid_fight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
